// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle Small-MIPS main controller.
// Holds the FSM state encoding, opcode/funct constants, ALU control codes,
// datapath mux select encodings and small decode helpers.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the unified memory and are covered by the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

  function automatic logic legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// master: the controller (reads instruction fields and status, drives
//         selects, enables and memory request).
// slave : the datapath/memory side.
interface mips_multicycle_ctrl_if;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_mem_req;
  logic       o_mem_write;
  logic       o_i_or_d;
  logic       o_ir_write;
  logic       o_pc_write;
  logic       o_reg_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_pc_src;
  logic [2:0] o_alu_control;
  logic       o_illegal;
  logic       o_halted;
  logic [3:0] o_state;

  modport master (
    input  i_opcode, i_funct, i_zero, i_mem_ready,
    output o_mem_req, o_mem_write, o_i_or_d, o_ir_write, o_pc_write,
           o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
           o_pc_src, o_alu_control, o_illegal, o_halted, o_state
  );

  modport slave (
    output i_opcode, i_funct, i_zero, i_mem_ready,
    input  o_mem_req, o_mem_write, o_i_or_d, o_ir_write, o_pc_write,
           o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
           o_pc_src, o_alu_control, o_illegal, o_halted, o_state
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU operation decoder for R-type instructions.
// i_is_execute : controller is in EXECUTE
// i_funct      : instr[5:0]
// o_alu_control: ALU op; add when not executing or funct is unrecognised
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic       i_is_execute,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control
);

  // Funct-to-ALU mapping; unknown funct quietly falls back to add.
  always_comb begin
    o_alu_control = ALU_ADD;
    if (i_is_execute) begin
      case (i_funct)
        FN_ADD:  o_alu_control = ALU_ADD;
        FN_SUB:  o_alu_control = ALU_SUB;
        FN_AND:  o_alu_control = ALU_AND;
        FN_OR:   o_alu_control = ALU_OR;
        FN_SLT:  o_alu_control = ALU_SLT;
        default: o_alu_control = ALU_ADD;
      endcase
    end else begin
      o_alu_control = ALU_ADD;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle Small-MIPS datapath.
// i_clk, i_rst : clock and synchronous active-high reset
// bus (master) : instruction fields, ALU zero, memory ready in;
//                mux selects, write enables, memory request, ALU control,
//                illegal-opcode pulse, halt flag and debug state out.
// Memory waits in FETCH/MEMRD/MEMWR are bounded by TIMEOUT_CYCLES; on expiry
// the FSM parks in HALT until reset.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mips_multicycle_ctrl_if.master bus
);

  state_t            state_r;
  state_t            state_next_s;
  logic [TO_W-1:0]   wait_cnt_r;
  logic              timeout_s;
  logic [2:0]        dec_alu_s;

  logic       mem_req_s, mem_write_s, i_or_d_s, ir_write_s, pc_write_s;
  logic       reg_write_s, reg_dst_s, mem_to_reg_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, pc_src_s;
  logic [2:0] alu_ctl_s;
  logic       illegal_s, halted_s;

  mips_alu_decoder u_alu_dec (
    .i_is_execute  (state_r == ST_EXECUTE),
    .i_funct       (bus.i_funct),
    .o_alu_control (dec_alu_s)
  );

  // Next-state selection; a ready in the timeout cycle still completes the access.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = (wait_cnt_r == TO_W'(TIMEOUT_CYCLES)) && !bus.i_mem_ready;
    case (state_r)
      ST_FETCH: begin
        if (bus.i_mem_ready)  state_next_s = ST_DECODE;
        else if (timeout_s)   state_next_s = ST_HALT;
        else                  state_next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (bus.i_opcode)
          OP_LW, OP_SW: state_next_s = ST_MEMADR;
          OP_RTYPE:     state_next_s = ST_EXECUTE;
          OP_BEQ:       state_next_s = ST_BRANCH;
          OP_ADDI:      state_next_s = ST_ADDIEX;
          OP_J:         state_next_s = ST_JUMP;
          default:      state_next_s = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (bus.i_opcode == OP_LW) state_next_s = ST_MEMRD;
        else                       state_next_s = ST_MEMWR;
      end
      ST_MEMRD: begin
        if (bus.i_mem_ready)  state_next_s = ST_MEMWB;
        else if (timeout_s)   state_next_s = ST_HALT;
        else                  state_next_s = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (bus.i_mem_ready)  state_next_s = ST_FETCH;
        else if (timeout_s)   state_next_s = ST_HALT;
        else                  state_next_s = ST_MEMWR;
      end
      ST_MEMWB:   state_next_s = ST_FETCH;
      ST_EXECUTE: state_next_s = ST_ALUWB;
      ST_ALUWB:   state_next_s = ST_FETCH;
      ST_BRANCH:  state_next_s = ST_FETCH;
      ST_ADDIEX:  state_next_s = ST_ADDIWB;
      ST_ADDIWB:  state_next_s = ST_FETCH;
      ST_JUMP:    state_next_s = ST_FETCH;
      ST_HALT:    state_next_s = ST_HALT;
      default:    state_next_s = ST_FETCH;
    endcase
  end

  // State register and per-access wait counter (cleared whenever the state changes).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s != state_r) begin
        wait_cnt_r <= '0;
      end else if (is_wait_state(state_r) && !bus.i_mem_ready) begin
        wait_cnt_r <= wait_cnt_r + TO_W'(1);
      end
    end
  end

  // Per-state datapath controls; anything a state does not mention stays 0.
  always_comb begin
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    i_or_d_s     = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_REG;
    pc_src_s     = PCSRC_ALU;
    alu_ctl_s    = 3'b000;
    illegal_s    = 1'b0;
    halted_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        alu_ctl_s   = ALU_ADD;
        ir_write_s  = bus.i_mem_ready;
        pc_write_s  = bus.i_mem_ready;
      end
      ST_DECODE: begin
        // Branch target PC + (imm << 2) is precomputed into ALUOut here.
        alu_src_b_s = SRCB_IMM_SH2;
        alu_ctl_s   = ALU_ADD;
        illegal_s   = !legal_opcode(bus.i_opcode);
      end
      ST_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        alu_ctl_s   = ALU_ADD;
      end
      ST_MEMRD: begin
        mem_req_s = 1'b1;
        i_or_d_s  = 1'b1;
      end
      ST_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      ST_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        i_or_d_s    = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a_s = 1'b1;
        alu_ctl_s   = dec_alu_s;
      end
      ST_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_s = 1'b1;
        alu_ctl_s   = ALU_SUB;
        pc_src_s    = PCSRC_ALUOUT;
        pc_write_s  = bus.i_zero;
      end
      ST_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        alu_ctl_s   = ALU_ADD;
      end
      ST_ADDIWB: reg_write_s = 1'b1;
      ST_JUMP: begin
        pc_src_s   = PCSRC_JUMP;
        pc_write_s = 1'b1;
      end
      ST_HALT:  halted_s = 1'b1;
      default:  halted_s = 1'b0;
    endcase
  end

  // Reset suppresses every side effect in the cycle it is asserted.
  assign bus.o_mem_req     = mem_req_s   & ~i_rst;
  assign bus.o_mem_write   = mem_write_s & ~i_rst;
  assign bus.o_ir_write    = ir_write_s  & ~i_rst;
  assign bus.o_pc_write    = pc_write_s  & ~i_rst;
  assign bus.o_reg_write   = reg_write_s & ~i_rst;
  assign bus.o_illegal     = illegal_s   & ~i_rst;
  assign bus.o_halted      = halted_s    & ~i_rst;
  assign bus.o_i_or_d      = i_or_d_s;
  assign bus.o_reg_dst     = reg_dst_s;
  assign bus.o_mem_to_reg  = mem_to_reg_s;
  assign bus.o_alu_src_a   = alu_src_a_s;
  assign bus.o_alu_src_b   = alu_src_b_s;
  assign bus.o_pc_src      = pc_src_s;
  assign bus.o_alu_control = alu_ctl_s;
  assign bus.o_state       = state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each scenario queues a list
// of named instruction steps; a reference model turns each step into the
// full set of expected controls, compared every cycle at the falling edge.
module tb_mips_multicycle_ctrl;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctl;
    logic       illegal;
    logic       halted;
    logic       at_fetch;
  } obs_t;

  int vectors = 0;
  int errors  = 0;

  string      step_q[$];
  bit         rdy_q[$];
  bit         z_q[$];
  bit         rst_q[$];
  logic [5:0] op_q[$];
  logic [5:0] fn_q[$];

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic obs_t expect_step(input string s, input bit rdy, input bit z,
                                       input bit rst, input logic [5:0] fn);
    obs_t e;
    e = '0;
    case (s)
      "FETCH":   begin e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_ctl = 3'b010;
                       e.ir_write = rdy; e.pc_write = rdy; e.at_fetch = 1'b1; end
      "DECODE":  begin e.alu_src_b = 2'b11; e.alu_ctl = 3'b010; end
      "DECODE_BAD": begin e.alu_src_b = 2'b11; e.alu_ctl = 3'b010; e.illegal = 1'b1; end
      "MEMADR":  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl = 3'b010; end
      "MEMRD":   begin e.mem_req = 1'b1; e.i_or_d = 1'b1; end
      "MEMWB":   begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      "MEMWR":   begin e.mem_req = 1'b1; e.mem_write = 1'b1; e.i_or_d = 1'b1; end
      "EXECUTE": begin e.alu_src_a = 1'b1; e.alu_ctl = alu_of(fn); end
      "ALUWB":   begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      "BRANCH":  begin e.alu_src_a = 1'b1; e.alu_ctl = 3'b110; e.pc_src = 2'b01;
                       e.pc_write = z; end
      "ADDIEX":  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl = 3'b010; end
      "ADDIWB":  begin e.reg_write = 1'b1; end
      "JUMP":    begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      "HALT":    begin e.halted = 1'b1; end
      default:   e = '1;
    endcase
    if (rst) begin
      e.ir_write = 1'b0; e.pc_write = 1'b0; e.reg_write = 1'b0; e.mem_write = 1'b0;
      e.mem_req = 1'b0; e.illegal = 1'b0; e.halted = 1'b0;
    end
    return e;
  endfunction

  task automatic push(input string s, input bit r, input bit z, input bit rs,
                      input logic [5:0] op, input logic [5:0] fn);
    step_q.push_back(s); rdy_q.push_back(r); z_q.push_back(z);
    rst_q.push_back(rs); op_q.push_back(op); fn_q.push_back(fn);
  endtask

  // One instruction: fw fetch wait cycles, mw memory wait cycles, zero flag for beq.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input bit z);
    for (int i = 0; i < fw; i++) push("FETCH", 1'b0, 1'($urandom), 1'b0, op, fn);
    push("FETCH", 1'b1, 1'($urandom), 1'b0, op, fn);
    case (op)
      6'b100011, 6'b101011: begin
        push("DECODE", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("MEMADR", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        for (int i = 0; i < mw; i++)
          push((op == 6'b100011) ? "MEMRD" : "MEMWR", 1'b0, 1'($urandom), 1'b0, op, fn);
        push((op == 6'b100011) ? "MEMRD" : "MEMWR", 1'b1, 1'($urandom), 1'b0, op, fn);
        if (op == 6'b100011) push("MEMWB", 1'($urandom), 1'($urandom), 1'b0, op, fn);
      end
      6'b000000: begin
        push("DECODE", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("EXECUTE", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("ALUWB", 1'($urandom), 1'($urandom), 1'b0, op, fn);
      end
      6'b000100: begin
        push("DECODE", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("BRANCH", 1'($urandom), z, 1'b0, op, fn);
      end
      6'b001000: begin
        push("DECODE", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("ADDIEX", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("ADDIWB", 1'($urandom), 1'($urandom), 1'b0, op, fn);
      end
      6'b000010: begin
        push("DECODE", 1'($urandom), 1'($urandom), 1'b0, op, fn);
        push("JUMP", 1'($urandom), 1'($urandom), 1'b0, op, fn);
      end
      default: push("DECODE_BAD", 1'($urandom), 1'($urandom), 1'b0, op, fn);
    endcase
  endtask

  // Applies the next queued step: drive after the rising edge, sample at the falling edge.
  task automatic step(output obs_t got, output obs_t want, output string nm);
    string s; bit r, z, rs; logic [5:0] op, fn;
    s = step_q.pop_front(); r = rdy_q.pop_front(); z = z_q.pop_front();
    rs = rst_q.pop_front(); op = op_q.pop_front(); fn = fn_q.pop_front();
    i_rst = rs; bus.i_mem_ready = r; bus.i_zero = z; bus.i_opcode = op; bus.i_funct = fn;
    @(negedge i_clk);
    got.mem_req = bus.o_mem_req;     got.mem_write = bus.o_mem_write;
    got.i_or_d = bus.o_i_or_d;       got.ir_write = bus.o_ir_write;
    got.pc_write = bus.o_pc_write;   got.reg_write = bus.o_reg_write;
    got.reg_dst = bus.o_reg_dst;     got.mem_to_reg = bus.o_mem_to_reg;
    got.alu_src_a = bus.o_alu_src_a; got.alu_src_b = bus.o_alu_src_b;
    got.pc_src = bus.o_pc_src;       got.alu_ctl = bus.o_alu_control;
    got.illegal = bus.o_illegal;     got.halted = bus.o_halted;
    got.at_fetch = (bus.o_state == 4'd0);
    want = expect_step(s, r, z, rs, fn);
    nm = s;
    @(posedge i_clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t got, want; string nm;
    for (int i = 0; i < 3; i++) push("FETCH", 1'b1, 1'b0, 1'b1, 6'b000000, 6'b100000);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL reset/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  task automatic test_rtype_add();
    obs_t got, want; string nm;
    push_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
    push("FETCH", 1'b0, 1'b0, 1'b0, 6'b000000, 6'b100000);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL rtype/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  task automatic test_lw_waits();
    obs_t got, want; string nm; int irw = 0; int ret = -1; int i = 0; bit left = 1'b0;
    push_instr(6'b100011, 6'b000000, 3, 2, 1'b0);
    push("FETCH", 1'b0, 1'b0, 1'b0, 6'b100011, 6'b000000);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL lw/%s got=%h want=%h", nm, got, want); end
      if (got.ir_write === 1'b1) irw++;
      if (got.at_fetch !== 1'b1) left = 1'b1;
      else if (left && ret < 0) ret = i;
      i++;
    end
    vectors++;
    if (irw !== 1) begin errors++; $display("FAIL lw_ir_write_count got=%0d want=1", irw); end
    vectors++;
    if (ret !== 10) begin errors++; $display("FAIL lw_cycles got=%0d want=10", ret); end
  endtask

  task automatic test_beq();
    obs_t got, want; string nm;
    push_instr(6'b000100, 6'($urandom), 0, 0, 1'b1);
    push_instr(6'b000100, 6'($urandom), 0, 0, 1'b0);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL beq/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  task automatic test_illegal();
    obs_t got, want; string nm;
    push_instr(6'b111111, 6'b100000, 0, 0, 1'b0);
    push("FETCH", 1'b0, 1'b0, 1'b0, 6'b111111, 6'b100000);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL illegal/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  task automatic test_timeout();
    obs_t got, want; string nm;
    push("FETCH", 1'b1, 1'b0, 1'b0, 6'b101011, 6'b000000);
    push("DECODE", 1'b0, 1'b0, 1'b0, 6'b101011, 6'b000000);
    push("MEMADR", 1'b0, 1'b0, 1'b0, 6'b101011, 6'b000000);
    for (int i = 0; i < 17; i++) push("MEMWR", 1'b0, 1'b0, 1'b0, 6'b101011, 6'b000000);
    for (int i = 0; i < 4; i++) push("HALT", 1'($urandom), 1'b0, 1'b0, 6'b101011, 6'b000000);
    push("HALT", 1'b1, 1'b0, 1'b1, 6'b101011, 6'b000000);
    push("FETCH", 1'b1, 1'b0, 1'b1, 6'b101011, 6'b000000);
    // Ready arrives in the 17th wait cycle: completes without halting.
    push_instr(6'b101011, 6'b000000, 0, 16, 1'b0);
    push("FETCH", 1'b0, 1'b0, 1'b0, 6'b101011, 6'b000000);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL timeout/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, want; string nm;
    push("FETCH", 1'b1, 1'b0, 1'b0, 6'b100011, 6'b000000);
    push("DECODE", 1'b1, 1'b0, 1'b0, 6'b100011, 6'b000000);
    push("MEMADR", 1'b1, 1'b0, 1'b0, 6'b100011, 6'b000000);
    push("MEMRD", 1'b1, 1'b0, 1'b0, 6'b100011, 6'b000000);
    push("MEMWB", 1'b1, 1'b0, 1'b1, 6'b100011, 6'b000000);
    push("FETCH", 1'b1, 1'b0, 1'b1, 6'b100011, 6'b000000);
    push("FETCH", 1'b1, 1'b0, 1'b1, 6'b100011, 6'b000000);
    push_instr(6'b100011, 6'b000000, 1, 1, 1'b0);
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL reset_mid/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, want; string nm;
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 30; n++) begin
      logic [5:0] op, fn;
      int pick;
      pick = int'($urandom_range(0, 6));
      if (pick < 6) op = ops[pick];
      else begin
        op = 6'($urandom);
        while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
          op = 6'($urandom);
      end
      pick = int'($urandom_range(0, 5));
      fn = (pick < 5) ? fns[pick] : 6'($urandom);
      push_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end
    while (step_q.size() != 0) begin
      step(got, want, nm); vectors++;
      if (got !== want) begin errors++; $display("FAIL random/%s got=%h want=%h", nm, got, want); end
    end
  endtask

  initial begin
    bus.i_opcode = 6'b000000; bus.i_funct = 6'b000000;
    bus.i_zero = 1'b0; bus.i_mem_ready = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    test_reset();
    test_rtype_add();
    test_lw_waits();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
